bit_population_accumulator: RTL
===============================

# bit_population_accumulator

Downstream consumer of the bit population counter. Takes the per-word popcount and its valid strobe, and groups valid samples into frames of FRAME_LEN. For each frame it produces the frame sum, the maximum popcount and the sample count as a registered, single-cycle result. A frame can also be closed early with a flush request.

## Interface

Parameters:

- WIDTH, 8: upstream data word width; popcount input is $clog2(WIDTH)+1 bits.
- FRAME_LEN, 16: valid samples per frame, legal range 1..1024.
- SUM_WIDTH, 16: width of frame sum accumulator, minimum 1.

Ports:

- clk  in  1  single clock; all logic on posedge.
- srst_i  in  1  reset, synchronous, active-low.
- data_i  in  $clog2(WIDTH)+1  popcount from upstream stage; values above WIDTH are out of contract.
- data_val_i  in  1  data_i valid; no backpressure, every valid cycle is one sample.
- flush_i  in  1  close the current frame early.
- sum_o  out  SUM_WIDTH  frame sum.
- max_o  out  $clog2(WIDTH)+1  largest data_i in frame.
- cnt_o  out  $clog2(FRAME_LEN)+1  samples in frame.
- ovf_o  out  1  frame sum exceeded 2^SUM_WIDTH-1.
- sum_val_o  out  1  one-cycle pulse; sum_o/max_o/cnt_o/ovf_o valid.

## Operation

- The FSM has two states:
  - IDLE: no samples in the current frame.
  - ACC: one or more samples in the current frame.
- Each valid sample does the following:
  - acc_sum += data_i.
  - acc_max = max(acc_max, data_i).
  - acc_cnt += 1.
  - acc_ovf is set if the addition carries out of SUM_WIDTH.
- IDLE moves to ACC on a valid sample, unless that sample itself closes the frame.
- A frame closes in either of these cases:
  - The accepted sample makes acc_cnt == FRAME_LEN.
  - flush_i=1 while the frame holds at least one sample, counting any sample accepted in the same cycle.
- On frame close:
  - The result registers load the final values, including the closing sample.
  - sum_val_o pulses.
  - The accumulators clear and the FSM returns to IDLE.
- flush_i in IDLE with data_val_i=0 has no effect and produces no pulse.
- flush_i and data_val_i together in IDLE close a 1-sample frame.
- FRAME_LEN=1: every valid sample closes a frame; the FSM stays in IDLE.
- Outputs hold their last result until the next frame close. They are not cleared after the pulse.
- ovf_o is sticky within a frame and clears with the accumulators.
- Arithmetic: acc_sum is computed SUM_WIDTH+1 bits internally for carry detection. acc_cnt never exceeds FRAME_LEN.

## Timing

- Reset (srst_i=0 at a posedge) sets:
  - FSM to IDLE.
  - All accumulators to 0.
  - sum_o=0, max_o=0, cnt_o=0, ovf_o=0, sum_val_o=0.
- Reset mid-frame discards the partial frame with no pulse. Inputs are ignored while srst_i=0.
- Latency: sum_val_o asserts exactly 1 cycle after the posedge that accepts the closing sample or flush.
- Back-to-back frames are supported. A valid sample in the cycle after the closing sample belongs to the new frame, so there are no dead cycles.
- Throughput is one sample per clock, sustained indefinitely.
- sum_val_o is never high on two consecutive cycles unless FRAME_LEN=1 with continuous valid input, or flushes occur on consecutive valid cycles.

## Configuration

- Macro BIT_POPULATION_ACCUMULATOR_SATURATE_EN.
- Defined: on overflow, acc_sum clamps at 2^SUM_WIDTH-1 and stays there for the rest of the frame.
- Undefined: acc_sum wraps modulo 2^SUM_WIDTH.
- ovf_o behaves identically in both builds.

## Test plan

All scenarios use WIDTH=8, FRAME_LEN=4, SUM_WIDTH=16 unless stated.

- Continuous valid input 3,5,8,0 -> 1 cycle after the 4th sample: sum_val_o=1, sum_o=16, max_o=8, cnt_o=4, ovf_o=0; outputs hold afterwards.
- Same samples with data_val_i=0 gaps of 0–3 cycles between them, random data_i during gaps -> identical single result (16, 8, 4); gap data ignored.
- Samples 7,1, with flush_i=1 on the cycle of the 1 -> sum_o=8, max_o=7, cnt_o=2. A later flush_i in IDLE -> no pulse, outputs unchanged.
- SUM_WIDTH=4, samples 8,8,8,8:
  - Macro undefined: sum_o=0, ovf_o=1.
  - Macro defined: sum_o=15, ovf_o=1.
  - The next frame 1,1,1,1 gives sum_o=4, ovf_o=0.
- Samples 5,5, then srst_i=0 for 2 cycles, then 1,1,1,1 -> no pulse before reset release; exactly one pulse with sum_o=4, cnt_o=4, max_o=1.
- 8 consecutive valid samples of value 2 -> two pulses 4 cycles apart, each with sum_o=8, cnt_o=4, max_o=2.

Source files
------------

// File: rtl/bit_population_accumulator.sv
// bit_population_accumulator: groups popcount samples into frames and
// reports frame sum, maximum and sample count as a registered one-cycle result.
//
// Ports:
//   clk        - clock, all logic on posedge
//   srst_i     - synchronous active-low reset
//   data_i     - popcount sample from upstream ($clog2(WIDTH)+1 bits)
//   data_val_i - data_i valid, one sample per valid cycle
//   flush_i    - close the current frame early
//   sum_o      - frame sum (SUM_WIDTH bits)
//   max_o      - largest sample in the frame
//   cnt_o      - samples in the frame
//   ovf_o      - frame sum exceeded 2^SUM_WIDTH-1
//   sum_val_o  - one-cycle pulse, result outputs valid
//
// Build option: BIT_POPULATION_ACCUMULATOR_SATURATE_EN clamps the frame sum
// at 2^SUM_WIDTH-1 on overflow instead of wrapping.

module bit_population_accumulator #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 16,
    parameter int SUM_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         srst_i,
    input  logic [$clog2(WIDTH):0]       data_i,
    input  logic                         data_val_i,
    input  logic                         flush_i,
    output logic [SUM_WIDTH-1:0]         sum_o,
    output logic [$clog2(WIDTH):0]       max_o,
    output logic [$clog2(FRAME_LEN):0]   cnt_o,
    output logic                         ovf_o,
    output logic                         sum_val_o
);

    localparam int DW = $clog2(WIDTH) + 1;
    localparam int CW = $clog2(FRAME_LEN) + 1;
    // Adder is wide enough for both operands plus a carry bit.
    localparam int EW = ((SUM_WIDTH > DW) ? SUM_WIDTH : DW) + 1;

    typedef enum logic {
        IDLE,
        ACC
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [SUM_WIDTH-1:0] acc_sum;
    logic [DW-1:0]        acc_max;
    logic [CW-1:0]        acc_cnt;
    logic                 acc_ovf;

    logic [EW-1:0]        sum_ext;
    logic                 carry;
    logic [SUM_WIDTH-1:0] n_sum;
    logic [DW-1:0]        n_max;
    logic [CW-1:0]        n_cnt;
    logic                 n_ovf;
    logic                 has_smp;
    logic                 cnt_hit;
    logic                 close;

    // Accumulator values including this cycle's sample, if any.
    always_comb begin
        sum_ext = {{(EW-SUM_WIDTH){1'b0}}, acc_sum}
                + {{(EW-DW){1'b0}}, data_i};
        carry   = |sum_ext[EW-1:SUM_WIDTH];
        n_sum   = acc_sum;
        n_max   = acc_max;
        n_cnt   = acc_cnt;
        n_ovf   = acc_ovf;
        if (data_val_i) begin
`ifdef BIT_POPULATION_ACCUMULATOR_SATURATE_EN
            // Once clamped, any further add carries again, so it stays.
            n_sum = carry ? {SUM_WIDTH{1'b1}} : sum_ext[SUM_WIDTH-1:0];
`else
            n_sum = sum_ext[SUM_WIDTH-1:0];
`endif
            n_max = (data_i > acc_max) ? data_i : acc_max;
            n_cnt = acc_cnt + CW'(1);
            n_ovf = acc_ovf | carry;
        end
    end

    // A flush needs at least one sample, counting one arriving now.
    always_comb begin
        has_smp = (state_q == ACC) || data_val_i;
        cnt_hit = data_val_i && (n_cnt == CW'(FRAME_LEN));
        close   = cnt_hit || (flush_i && has_smp);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (data_val_i && !close) state_d = ACC;
            ACC:  if (close) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!srst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_i) begin
            acc_sum   <= '0;
            acc_max   <= '0;
            acc_cnt   <= '0;
            acc_ovf   <= 1'b0;
            sum_o     <= '0;
            max_o     <= '0;
            cnt_o     <= '0;
            ovf_o     <= 1'b0;
            sum_val_o <= 1'b0;
        end else if (close) begin
            sum_o     <= n_sum;
            max_o     <= n_max;
            cnt_o     <= n_cnt;
            ovf_o     <= n_ovf;
            sum_val_o <= 1'b1;
            acc_sum   <= '0;
            acc_max   <= '0;
            acc_cnt   <= '0;
            acc_ovf   <= 1'b0;
        end else begin
            acc_sum   <= n_sum;
            acc_max   <= n_max;
            acc_cnt   <= n_cnt;
            acc_ovf   <= n_ovf;
            sum_val_o <= 1'b0;
        end
    end

endmodule
